// File: rtl/axi_lite_bus_arbiter.sv
// Shares one AXI4-lite memory port between the IFU (read-only) and the LSU (read/write).
// One transaction at a time; the owner holds the port until its R or B handshake completes.
module axi_lite_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    // IFU read port
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,

    // LSU read port
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,

    // LSU write port
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,

    // Memory-side port
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_rready,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    output logic                m_bready,

    output logic [1:0]          grant,
    output logic [1:0]          dbg_state
);

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both high; valid, once raised, holds with stable payload
    // until that edge, and ready may depend on valid.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;
    logic   w_ar_hs;
    logic   w_aw_hs;
    logic   w_w_hs;

    assign w_ar_hs   = m_arvalid && m_arready;
    assign w_aw_hs   = m_awvalid && m_awready;
    assign w_w_hs    = m_wvalid && m_wready;
    assign dbg_state = r_state;

    // Done flags live only for one transaction; they clear whenever we head back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == ST_IDLE) begin
                r_ar_done <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_ar_hs) r_ar_done <= 1'b1;
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        grant        = 2'b00;

        ifu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        ifu_rdata    = '0;
        ifu_rresp    = 2'b00;

        lsu_arready  = 1'b0;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = '0;
        lsu_rresp    = 2'b00;
        lsu_awready  = 1'b0;
        lsu_wready   = 1'b0;
        lsu_bvalid   = 1'b0;
        lsu_bresp    = 2'b00;

        m_arvalid    = 1'b0;
        m_araddr     = '0;
        m_rready     = 1'b0;
        m_awvalid    = 1'b0;
        m_awaddr     = '0;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = '0;
        m_bready     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // LSU write beats LSU read beats IFU fetch.
                if (lsu_awvalid || lsu_wvalid) begin
                    w_next_state = ST_LSU_WR;
                end else if (lsu_arvalid) begin
                    w_next_state = ST_LSU_RD;
                end else if (ifu_arvalid) begin
                    w_next_state = ST_IFU_RD;
                end
            end

            ST_IFU_RD: begin
                grant       = 2'b01;
                m_arvalid   = ifu_arvalid && !r_ar_done;
                m_araddr    = ifu_araddr;
                ifu_arready = m_arready && !r_ar_done;
                m_rready    = ifu_rready;
                ifu_rvalid  = m_rvalid;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                if (m_rvalid && ifu_rready) begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_LSU_RD: begin
                grant       = 2'b10;
                m_arvalid   = lsu_arvalid && !r_ar_done;
                m_araddr    = lsu_araddr;
                lsu_arready = m_arready && !r_ar_done;
                m_rready    = lsu_rready;
                lsu_rvalid  = m_rvalid;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                if (m_rvalid && lsu_rready) begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_LSU_WR: begin
                grant       = 2'b10;
                m_awvalid   = lsu_awvalid && !r_aw_done;
                m_awaddr    = lsu_awaddr;
                lsu_awready = m_awready && !r_aw_done;
                m_wvalid    = lsu_wvalid && !r_w_done;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                lsu_wready  = m_wready && !r_w_done;
                m_bready    = lsu_bready;
                lsu_bvalid  = m_bvalid;
                lsu_bresp   = m_bresp;
                // An early B (before AW/W both completed) is still accepted and ends the write.
                if (m_bvalid && lsu_bready) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Bench for axi_lite_bus_arbiter: requester driver tasks, a delay-programmable memory slave,
// and an ordered scoreboard of {owner, resp, data} responses.
module tb_axi_lite_bus_arbiter;

    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        rst;

    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;

    logic        lsu_arvalid;
    logic [31:0] lsu_araddr;
    logic        lsu_arready;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rready;
    logic        lsu_awvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awready;
    logic        lsu_wvalid;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wready;
    logic        lsu_bvalid;
    logic [1:0]  lsu_bresp;
    logic        lsu_bready;

    logic        m_arvalid;
    logic [31:0] m_araddr;
    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rready;
    logic        m_awvalid;
    logic [31:0] m_awaddr;
    logic        m_awready;
    logic        m_wvalid;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wready;
    logic        m_bvalid;
    logic [1:0]  m_bresp;
    logic        m_bready;

    logic [1:0]  grant;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    axi_lite_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .grant(grant), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    logic [11:0] w_hs_outs;
    assign w_hs_outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                        lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};

    // ---------------- memory slave model ----------------
    int          sl_ar_delay = 0, sl_r_delay = 0, sl_aw_delay = 0, sl_w_delay = 0, sl_b_delay = 0;
    logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;
    logic        sl_fixed_en = 1'b0;
    logic [31:0] sl_fixed_rdata = 32'h0;

    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic        r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] r_data_q = 32'h0;
    int          ar_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
    logic [31:0] got_araddr = 32'h0, got_awaddr = 32'h0, got_wdata = 32'h0;
    logic [3:0]  got_wstrb = 4'h0;
    time         aw_hs_t = 0, w_hs_t = 0;
    int          ar_proto_err = 0;
    logic        prev_ar_pend = 1'b0;
    logic [31:0] prev_araddr = 32'h0;
    int          iso_err = 0;

    assign m_arready = m_arvalid && (ar_wait >= sl_ar_delay);
    assign m_rvalid  = r_pend && (r_wait >= sl_r_delay);
    assign m_rdata   = m_rvalid ? r_data_q : 32'h0;
    assign m_rresp   = m_rvalid ? sl_rresp : 2'b00;
    assign m_awready = m_awvalid && !aw_got && (aw_wait >= sl_aw_delay);
    assign m_wready  = m_wvalid && !w_got && (w_wait >= sl_w_delay);
    assign m_bvalid  = aw_got && w_got && (b_wait >= sl_b_delay);
    assign m_bresp   = m_bvalid ? sl_bresp : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            ar_wait <= 0; r_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; prev_ar_pend <= 1'b0;
        end else begin
            if (m_rvalid && m_rready) begin
                r_pend <= 1'b0;
                r_wait <= 0;
            end else if (r_pend) begin
                r_wait <= r_wait + 1;
            end
            if (m_arvalid && m_arready) begin
                ar_wait    <= 0;
                r_pend     <= 1'b1;
                r_wait     <= 0;
                r_data_q   <= sl_fixed_en ? sl_fixed_rdata : (m_araddr ^ 32'hA5A5_0000);
                ar_hs_cnt  <= ar_hs_cnt + 1;
                got_araddr <= m_araddr;
            end else if (m_arvalid) begin
                ar_wait <= ar_wait + 1;
            end else begin
                ar_wait <= 0;
            end
            // A pending AR must stay valid with a stable address until accepted.
            if (prev_ar_pend && (!m_arvalid || m_araddr != prev_araddr)) ar_proto_err <= ar_proto_err + 1;
            prev_ar_pend <= m_arvalid && !m_arready;
            prev_araddr  <= m_araddr;

            if (m_bvalid && m_bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
                b_hs_cnt <= b_hs_cnt + 1;
            end else begin
                if (m_awvalid && m_awready) begin
                    aw_got <= 1'b1; aw_hs_cnt <= aw_hs_cnt + 1; got_awaddr <= m_awaddr; aw_hs_t <= $time;
                end else if (m_awvalid && !aw_got) begin
                    aw_wait <= aw_wait + 1;
                end
                if (m_wvalid && m_wready) begin
                    w_got <= 1'b1; w_hs_cnt <= w_hs_cnt + 1; got_wdata <= m_wdata; got_wstrb <= m_wstrb;
                    w_hs_t <= $time;
                end else if (m_wvalid && !w_got) begin
                    w_wait <= w_wait + 1;
                end
                if (aw_got && w_got) b_wait <= b_wait + 1;
            end
        end
        if (grant != 2'b01 && (ifu_arready || ifu_rvalid || ifu_rdata != 32'h0 || ifu_rresp != 2'b00))
            iso_err <= iso_err + 1;
        if (grant != 2'b10 && (lsu_arready || lsu_rvalid || lsu_awready || lsu_wready || lsu_bvalid ||
                               lsu_rdata != 32'h0 || lsu_rresp != 2'b00 || lsu_bresp != 2'b00))
            iso_err <= iso_err + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic rd_xact(input bit is_lsu, input logic [31:0] addr, input bit hold, output time t_r);
        int n;
        logic [1:0]  own;
        logic [31:0] d;
        logic [1:0]  r;
        logic [35:0] expv;
        logic [35:0] obs;
        own = is_lsu ? 2'b10 : 2'b01;
        t_r = 0;
        if (is_lsu) begin lsu_arvalid = 1'b1; lsu_araddr = addr; end
        else begin ifu_arvalid = 1'b1; ifu_araddr = addr; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(is_lsu ? lsu_arready : ifu_arready) && n < BUDGET);
        checks++;
        if (!(is_lsu ? lsu_arready : ifu_arready)) begin
            failures++;
            $display("FAIL ar_accept owner=%b addr=%h: arready=0 after %0d cycles, required 1", own, addr, n);
            if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
            return;
        end
        if (!hold) begin
            @(posedge clk); #1;
            if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(is_lsu ? lsu_rvalid : ifu_rvalid) && n < BUDGET);
        if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        checks++;
        if (!(is_lsu ? lsu_rvalid : ifu_rvalid)) begin
            failures++;
            $display("FAIL r_timeout owner=%b addr=%h: rvalid=0 after %0d cycles, required 1", own, addr, n);
            return;
        end
        t_r = $time;
        d = is_lsu ? lsu_rdata : ifu_rdata;
        r = is_lsu ? lsu_rresp : ifu_rresp;
        checks++;
        if (grant !== own) begin
            failures++;
            $display("FAIL grant_during_r addr=%h: got %b, required %b", addr, grant, own);
        end
        obs = {own, r, d};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL r_scoreboard addr=%h: got %h, required nothing (queue empty)", addr, obs);
        end else begin
            expv = exp_q.pop_front();
            if (obs !== expv) begin
                failures++;
                $display("FAIL r_scoreboard addr=%h: got %h, required %h", addr, obs, expv);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL grant_after_r addr=%h: got %b, required 00", addr, grant);
        end
    endtask

    task automatic wr_xact(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        logic [35:0] expv;
        logic [35:0] obs;
        lsu_awvalid = 1'b1; lsu_awaddr = addr;
        lsu_wvalid  = 1'b1; lsu_wdata  = data; lsu_wstrb = strb;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_bvalid && n < BUDGET);
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        checks++;
        if (!lsu_bvalid) begin
            failures++;
            $display("FAIL b_timeout addr=%h: bvalid=0 after %0d cycles, required 1", addr, n);
            return;
        end
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL grant_during_b addr=%h: got %b, required 10", addr, grant);
        end
        obs = {2'b10, lsu_bresp, 32'h0};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL b_scoreboard addr=%h: got %h, required nothing (queue empty)", addr, obs);
        end else begin
            expv = exp_q.pop_front();
            if (obs !== expv) begin
                failures++;
                $display("FAIL b_scoreboard addr=%h: got %h, required %h", addr, obs, expv);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL grant_after_b addr=%h: got %b, required 00", addr, grant);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant: got %b, required 00", grant);
        end
        checks++;
        if (w_hs_outs !== 12'h000) begin
            failures++;
            $display("FAIL reset_handshakes: got %h, required 000", w_hs_outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_ifu_read();
        time t;
        int  ar0;
        ar0 = ar_hs_cnt;
        sl_fixed_en = 1'b1; sl_fixed_rdata = 32'h0000_0413; sl_rresp = 2'b00;
        exp_q.push_back({2'b01, 2'b00, 32'h0000_0413});
        rd_xact(1'b0, 32'h8000_0000, 1'b0, t);
        checks++;
        if (got_araddr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL ifu_araddr: got %h, required 80000000", got_araddr);
        end
        checks++;
        if (ar_hs_cnt - ar0 !== 1) begin
            failures++;
            $display("FAIL ifu_ar_count: got %0d, required 1", ar_hs_cnt - ar0);
        end
        sl_fixed_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        time t_lsu, t_ifu;
        int  iso0;
        iso0 = iso_err;
        exp_q.push_back({2'b10, 2'b00, 32'h8000_1000 ^ 32'hA5A5_0000});
        exp_q.push_back({2'b01, 2'b00, 32'h8000_0040 ^ 32'hA5A5_0000});
        fork
            rd_xact(1'b1, 32'h8000_1000, 1'b0, t_lsu);
            rd_xact(1'b0, 32'h8000_0040, 1'b0, t_ifu);
        join
        checks++;
        if (t_ifu - t_lsu !== 30) begin
            failures++;
            $display("FAIL simul_order: ifu-lsu response gap %0t, required 30", t_ifu - t_lsu);
        end
        checks++;
        if (iso_err - iso0 !== 0) begin
            failures++;
            $display("FAIL simul_isolation: got %0d violations, required 0", iso_err - iso0);
        end
    endtask

    task automatic test_write_w_first();
        int aw0, w0, b0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        sl_aw_delay = 2; sl_w_delay = 0; sl_bresp = 2'b00;
        exp_q.push_back({2'b10, 2'b00, 32'h0});
        wr_xact(32'h8000_2000, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if ({aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL wr_counts: aw=%0d w=%0d b=%0d, required 1 1 1",
                     aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
        end
        checks++;
        if ({got_awaddr, got_wdata, got_wstrb} !== {32'h8000_2000, 32'hDEAD_BEEF, 4'hF}) begin
            failures++;
            $display("FAIL wr_payload: got %h/%h/%h, required 80002000/deadbeef/f",
                     got_awaddr, got_wdata, got_wstrb);
        end
        checks++;
        if (aw_hs_t - w_hs_t !== 20) begin
            failures++;
            $display("FAIL wr_w_before_aw: gap %0t, required 20", aw_hs_t - w_hs_t);
        end
        sl_aw_delay = 0;
    endtask

    task automatic test_read_delay();
        time t;
        int  ar0, pe0;
        ar0 = ar_hs_cnt; pe0 = ar_proto_err;
        sl_ar_delay = 3; sl_r_delay = 4;
        exp_q.push_back({2'b01, 2'b00, 32'h8000_3000 ^ 32'hA5A5_0000});
        rd_xact(1'b0, 32'h8000_3000, 1'b1, t);
        checks++;
        if (ar_hs_cnt - ar0 !== 1) begin
            failures++;
            $display("FAIL delay_ar_count: got %0d, required 1", ar_hs_cnt - ar0);
        end
        checks++;
        if (ar_proto_err - pe0 !== 0) begin
            failures++;
            $display("FAIL delay_ar_stable: got %0d violations, required 0", ar_proto_err - pe0);
        end
        sl_ar_delay = 0; sl_r_delay = 0;
    endtask

    task automatic test_reset_mid_write();
        time t;
        int  n;
        int  aw0;
        sl_w_delay = 6;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_4000;
        lsu_wvalid  = 1'b1; lsu_wdata  = 32'h1234_5678; lsu_wstrb = 4'h3;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_awready && n < BUDGET);
        checks++;
        if (!lsu_awready) begin
            failures++;
            $display("FAIL rstwr_aw_accept: awready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL rstwr_grant: got %b, required 00", grant);
        end
        checks++;
        if (w_hs_outs !== 12'h000) begin
            failures++;
            $display("FAIL rstwr_handshakes: got %h, required 000", w_hs_outs);
        end
        rst = 1'b0;
        sl_w_delay = 0;
        exp_q.push_back({2'b01, 2'b00, 32'h8000_0100 ^ 32'hA5A5_0000});
        rd_xact(1'b0, 32'h8000_0100, 1'b0, t);
        aw0 = aw_hs_cnt;
        exp_q.push_back({2'b10, 2'b00, 32'h0});
        wr_xact(32'h8000_4004, 32'hCAFE_F00D, 4'hC);
        checks++;
        if (aw_hs_cnt - aw0 !== 1 || got_awaddr !== 32'h8000_4004) begin
            failures++;
            $display("FAIL rstwr_next_aw: count %0d addr %h, required 1 80004004", aw_hs_cnt - aw0, got_awaddr);
        end
    endtask

    task automatic test_rresp_err();
        time t;
        sl_rresp = 2'b10;
        exp_q.push_back({2'b01, 2'b10, 32'h8000_0200 ^ 32'hA5A5_0000});
        rd_xact(1'b0, 32'h8000_0200, 1'b0, t);
        sl_rresp = 2'b00;
    endtask

    task automatic test_write_priority();
        time t;
        logic [31:0] a;
        a = 32'h8000_5000 + {20'h0, 12'(($urandom_range(0, 255)) << 2)};
        exp_q.push_back({2'b10, 2'b00, 32'h0});
        exp_q.push_back({2'b10, 2'b00, a ^ 32'hA5A5_0000});
        fork
            wr_xact(32'h8000_6000, $urandom, 4'h1);
            rd_xact(1'b1, a, 1'b0, t);
        join
    endtask

    task automatic test_back_to_back();
        time t0, t1, t2;
        logic [31:0] base;
        base = 32'h8000_0000 + {16'h0, 16'($urandom_range(0, 1023) << 4)};
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b01, 2'b00, (base + 32'(i * 4)) ^ 32'hA5A5_0000});
        rd_xact(1'b0, base, 1'b0, t0);
        rd_xact(1'b0, base + 32'd4, 1'b0, t1);
        rd_xact(1'b0, base + 32'd8, 1'b0, t2);
        checks++;
        if (t1 - t0 !== 30 || t2 - t1 !== 30) begin
            failures++;
            $display("FAIL b2b_period: gaps %0t %0t, required 30 30", t1 - t0, t2 - t1);
        end
    endtask

    task automatic test_final_state();
        checks++;
        if (iso_err !== 0) begin
            failures++;
            $display("FAIL isolation_total: got %0d violations, required 0", iso_err);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        ifu_arvalid = 1'b0; ifu_araddr = 32'h0; ifu_rready = 1'b1;
        lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_rready = 1'b1;
        lsu_awvalid = 1'b0; lsu_awaddr = 32'h0; lsu_wvalid = 1'b0; lsu_wdata = 32'h0;
        lsu_wstrb = 4'h0; lsu_bready = 1'b1;

        test_reset();
        test_ifu_read();
        test_simultaneous();
        test_write_w_first();
        test_read_delay();
        test_reset_mid_write();
        test_rresp_err();
        test_write_priority();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_final_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_bus_arbiter.md
Name: axi_lite_bus_arbiter

Overview:
- Sequential AXI4-lite arbiter that shares the single memory-side AXI-lite port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Grants one requester per transaction and holds the grant until that transaction's response handshake completes.
- Sits between IFU/LSU and the memory/crossbar slave.
- Replaces static external steering with an internal FSM.

Parameters:
ADDR_W, 32, address width of all AR/AW channels
DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ifu_arvalid/ifu_araddr  in  1/ADDR_W  IFU read address; ifu_arready out 1
ifu_rvalid/ifu_rdata/ifu_rresp  out  1/DATA_W/2  IFU read data; ifu_rready in 1
lsu_arvalid/lsu_araddr  in  1/ADDR_W  LSU read address; lsu_arready out 1
lsu_rvalid/lsu_rdata/lsu_rresp  out  1/DATA_W/2  LSU read data; lsu_rready in 1
lsu_awvalid/lsu_awaddr  in  1/ADDR_W  LSU write address; lsu_awready out 1
lsu_wvalid/lsu_wdata/lsu_wstrb  in  1/DATA_W/DATA_W/8  LSU write data; lsu_wready out 1
lsu_bvalid/lsu_bresp  out  1/2  LSU write response; lsu_bready in 1
m_arvalid/m_araddr  out  1/ADDR_W  memory read address; m_arready in 1
m_rvalid/m_rdata/m_rresp  in  1/DATA_W/2  memory read data; m_rready out 1
m_awvalid/m_awaddr  out  1/ADDR_W  memory write address; m_awready in 1
m_wvalid/m_wdata/m_wstrb  out  1/DATA_W/DATA_W/8  memory write data; m_wready in 1
m_bvalid/m_bresp  in  1/2  memory write response; m_bready out 1
grant  out  2  current owner: 00 none, 01 IFU, 10 LSU

Behaviour:
- FSM states and grant values:
  - IDLE: grant=00
  - IFU_RD: grant=01
  - LSU_RD: grant=10
  - LSU_WR: grant=10
  - All transitions are registered.
- IDLE arbitration, evaluated each cycle:
  - LSU_WR if lsu_awvalid or lsu_wvalid.
  - Else LSU_RD if lsu_arvalid.
  - Else IFU_RD if ifu_arvalid.
  - LSU has fixed priority over IFU, and LSU write has priority over LSU read.
  - In IDLE, all m_* valids/readies and all requester readies/valids are 0.
- Grant latency: one cycle. The request is sampled in IDLE, and channels are forwarded from the next cycle. Requesters hold valid per AXI rules.
- IFU_RD / LSU_RD:
  - Owner AR and R channels are connected combinationally to m_*.
  - m_araddr = owner address.
  - An internal ar_done flag sets on the m_arvalid&&m_arready handshake. After that, m_arvalid is forced to 0 so the address is issued exactly once.
  - Exit to IDLE on the cycle after m_rvalid&&m_rready.
- LSU_WR:
  - AW and W are forwarded independently. aw_done and w_done set on their respective handshakes, and each channel's valid is masked once its flag is set.
  - m_bready = lsu_bready; lsu_bvalid = m_bvalid.
  - Exit to IDLE after the B handshake. A B handshake before both flags are set is a slave protocol error and is still honoured.
- Non-owner isolation:
  - All ready and response-valid outputs to the non-owning requester are 0.
  - Its data/resp outputs are 0.
- Turnaround: at least one IDLE cycle between transactions, so back-to-back IFU fetches use 3+ cycles each with a zero-wait slave.
- Simultaneous requests: the loser keeps its valid asserted and is served on the next IDLE evaluation. No starvation guarantee for IFU is required, because the core serialises fetch and memory ops.
- m_rdata, m_rresp and m_bresp pass through unmodified; error responses are not interpreted.
- Reset:
  - State returns to IDLE, grant=00, and ar_done/aw_done/w_done clear.
  - All valid/ready outputs are 0 in the cycle after rst is sampled high, including when reset arrives mid-transaction. No outstanding transaction is tracked afterwards.

Test Plan:
- IFU read alone: ifu_araddr=0x8000_0000, slave arready/rvalid each 1-cycle, rdata=0x0000_0413 -> grant 01, ifu_rdata=0x0000_0413, rresp=00, back to grant 00 one cycle after R handshake.
- Simultaneous ifu_arvalid and lsu_arvalid (addr 0x8000_1000) in IDLE -> LSU_RD first; ifu_arready stays 0 until LSU R handshake completes, then IFU is served.
- LSU write with slave accepting W two cycles before AW: wdata=0xDEAD_BEEF, wstrb=0xF, awaddr=0x8000_2000 -> m_wvalid drops after its handshake, m_awvalid issued once, bresp=00 reaches LSU, FSM exits after B.
- Slave arready delayed 3 cycles and rvalid delayed 4 cycles -> m_arvalid held steady with stable address, exactly one AR handshake, no duplicate issue.
- Reset asserted while in LSU_WR with aw_done set -> next cycle grant=00 and all valids/readies 0; a new IFU request afterwards completes normally.
- Slave returns rresp=2'b10 to IFU -> ifu_rresp=2'b10 forwarded unchanged, FSM returns to IDLE.
